// File: rtl/instruction_fetch_pkg.sv
// Shared opcode, register, FSM-state and instruction-field definitions for the fetch stage.
package instruction_fetch_pkg;

  // Opcode encodings (instruction bits [27:24])
  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_MUL = 4'h3;
  localparam logic [3:0] OP_STO = 4'h4;
  localparam logic [3:0] OP_BLE = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;

  // Register encodings
  localparam logic [3:0] REG_R0 = 4'h0;
  localparam logic [3:0] REG_R1 = 4'h1;
  localparam logic [3:0] REG_R2 = 4'h2;
  localparam logic [3:0] REG_R3 = 4'h3;

  // Fetch FSM states
  localparam logic [0:0] ST_FETCH = 1'b0;
  localparam logic [0:0] ST_DELAY = 1'b1;

  // Instruction field positions
  localparam int OPC_HI   = 27;
  localparam int OPC_LO   = 24;
  localparam int OPND_HI  = 23;
  localparam int OPND_LO  = 0;
  localparam int JMPT_HI  = 15;
  localparam int JMPT_LO  = 0;

  localparam int INSTR_W  = 28;
  localparam int ADDR_W   = 16;
  localparam int COUNT_W  = 24;

  // Canonical NOP word with a zero operand
  function automatic logic [INSTR_W-1:0] nop_word();
    return {OP_NOP, {COUNT_W{1'b0}}};
  endfunction

endpackage

// File: rtl/fetch_delay_counter.sv
// Loadable 24-bit down-counter used to time NOP-with-count bubbles.
module fetch_delay_counter
  import instruction_fetch_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               clr_i,
  input  logic               load_i,
  input  logic               en_i,
  input  logic [COUNT_W-1:0] value_i,
  output logic [COUNT_W-1:0] count_o,
  output logic               zero_o
);

  logic [COUNT_W-1:0] cnt_q;

  // Clear wins over load; decrement saturates at zero
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= value_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign count_o = cnt_q;
  assign zero_o  = (cnt_q == '0);

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: PC, local JMP handling, NOP-count delay bubbles and branch redirect.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [15:0] RESET_ADDR = 16'd0,
  parameter bit          DELAY_EN   = 1'b1
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [27:0] iInstruction,
  input  logic        iStall,
  input  logic        iBranchTaken,
  input  logic [15:0] iBranchTarget,
  output logic [15:0] oAddress,
  output logic [27:0] oInstruction,
  output logic        oValid,
  output logic [15:0] oPC
);

  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               valid_q, valid_d;
  logic [ADDR_W-1:0]  opc_q, opc_d;
  logic [0:0]         state_q, state_d;

  logic               cnt_clr, cnt_load, cnt_en, cnt_zero;
  logic [COUNT_W-1:0] cnt_val;
  logic [3:0]         opcode;
  logic [COUNT_W-1:0] operand;

  assign opcode  = iInstruction[OPC_HI:OPC_LO];
  assign operand = iInstruction[OPND_HI:OPND_LO];

  fetch_delay_counter u_delay_cnt (
    .clk_i   (Clock),
    .rst_i   (Reset),
    .clr_i   (cnt_clr),
    .load_i  (cnt_load),
    .en_i    (cnt_en),
    .value_i (operand),
    .count_o (cnt_val),
    .zero_o  (cnt_zero)
  );

  // Next-state: branch redirect beats stall, which beats JMP/NOP/DELAY handling
  always_comb begin
    pc_d     = pc_q;
    instr_d  = instr_q;
    valid_d  = valid_q;
    opc_d    = opc_q;
    state_d  = state_q;
    cnt_clr  = 1'b0;
    cnt_load = 1'b0;
    cnt_en   = 1'b0;
    if (iBranchTaken) begin
      pc_d    = iBranchTarget;
      valid_d = 1'b0;
      state_d = ST_FETCH;
      cnt_clr = 1'b1;
    end else if (!iStall) begin
      case (state_q)
        ST_FETCH: begin
          opc_d = pc_q;
          if (opcode == OP_JMP) begin
            pc_d    = iInstruction[JMPT_HI:JMPT_LO];
            valid_d = 1'b0;
            instr_d = nop_word();
          end else if (DELAY_EN && (opcode == OP_NOP) && (operand != '0)) begin
            instr_d  = iInstruction;
            valid_d  = 1'b0;
            pc_d     = pc_q + 16'd1;
            cnt_load = 1'b1;
            state_d  = ST_DELAY;
          end else begin
            instr_d = iInstruction;
            valid_d = 1'b1;
            pc_d    = pc_q + 16'd1;
          end
        end
        ST_DELAY: begin
          valid_d = 1'b0;
          cnt_en  = 1'b1;
          // Leave on the edge where the counter reaches zero
          if (cnt_zero || (cnt_val == 24'd1)) begin
            state_d = ST_FETCH;
          end
        end
        default: state_d = ST_FETCH;
      endcase
    end
  end

  // Register update with synchronous reset overriding stall and branch
  always_ff @(posedge Clock) begin
    if (Reset) begin
      pc_q    <= RESET_ADDR;
      instr_q <= '0;
      valid_q <= 1'b0;
      opc_q   <= '0;
      state_q <= ST_FETCH;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      opc_q   <= opc_d;
      state_q <= state_d;
    end
  end

  assign oAddress     = pc_q;
  assign oInstruction = instr_q;
  assign oValid       = valid_q;
  assign oPC          = opc_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: vector table plus multi-cycle corner sequences.
module tb_instruction_fetch;
  import instruction_fetch_pkg::*;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic [27:0] iInstruction;
  logic        iStall = 1'b0;
  logic        iBranchTaken = 1'b0;
  logic [15:0] iBranchTarget = 16'd0;
  logic [15:0] oAddress;
  logic [27:0] oInstruction;
  logic        oValid;
  logic [15:0] oPC;

  logic [27:0] rom [65536];

  int checks = 0;
  int failures = 0;

  instruction_fetch #(.RESET_ADDR(16'd1), .DELAY_EN(1'b1)) dut (
    .Clock         (Clock),
    .Reset         (Reset),
    .iInstruction  (iInstruction),
    .iStall        (iStall),
    .iBranchTaken  (iBranchTaken),
    .iBranchTarget (iBranchTarget),
    .oAddress      (oAddress),
    .oInstruction  (oInstruction),
    .oValid        (oValid),
    .oPC           (oPC)
  );

  always #5 Clock = ~Clock;

  assign iInstruction = rom[oAddress];

  typedef struct {
    logic        stall;
    logic        br;
    logic [15:0] tgt;
    logic        exp_valid;
    logic [15:0] exp_pc;
    logic [15:0] exp_addr;
  } vec_t;

  vec_t vecs [24];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    iStall = 1'b0;
    iBranchTaken = 1'b0;
    step();
    step();
    Reset = 1'b0;
  endtask

  initial begin
    int n;
    for (int i = 0; i < 65536; i++) rom[i] = {OP_ADD, 8'h00, 16'(i)};
    rom[0] = {OP_NOP, 24'd2};
    rom[1] = {OP_STO, 24'h000101};
    rom[2] = {OP_STO, 24'h000202};
    rom[3] = {OP_MUL, 24'h000303};
    rom[7] = {OP_JMP, 24'h000000};

    //            stall br    tgt        valid  oPC       oAddress
    vecs[0]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0001, 16'h0002};
    vecs[1]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0002, 16'h0003};
    vecs[2]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0002, 16'h0003};
    vecs[3]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0002, 16'h0003};
    vecs[4]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0002, 16'h0003};
    vecs[5]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0003, 16'h0004};
    vecs[6]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0004, 16'h0005};
    vecs[7]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0005, 16'h0006};
    vecs[8]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0006, 16'h0007};
    vecs[9]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000};
    vecs[10] = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0001};
    vecs[11] = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0001};
    vecs[12] = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0001};
    vecs[13] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0001, 16'h0002};
    vecs[14] = '{1'b1, 1'b1, 16'h0040, 1'b0, 16'h0000, 16'h0040};
    vecs[15] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0040, 16'h0041};
    vecs[16] = '{1'b0, 1'b1, 16'hFFFF, 1'b0, 16'h0000, 16'hFFFF};
    vecs[17] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'hFFFF, 16'h0000};
    vecs[18] = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0001};
    vecs[19] = '{1'b1, 1'b1, 16'h0040, 1'b0, 16'h0000, 16'h0040};
    vecs[20] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0040, 16'h0041};
    vecs[21] = '{1'b0, 1'b1, 16'h0007, 1'b0, 16'h0000, 16'h0007};
    vecs[22] = '{1'b0, 1'b1, 16'h0020, 1'b0, 16'h0000, 16'h0020};
    vecs[23] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0020, 16'h0021};

    // Reset overrides stall and branch
    Reset = 1'b1;
    iStall = 1'b1;
    iBranchTaken = 1'b1;
    iBranchTarget = 16'h0055;
    step();
    step();
    check("rst_valid", 32'(oValid), 32'd0);
    check("rst_opc", 32'(oPC), 32'd0);
    check("rst_instr", 32'(oInstruction), 32'd0);
    check("rst_addr", 32'(oAddress), 32'd1);
    Reset = 1'b0;
    iStall = 1'b0;
    iBranchTaken = 1'b0;

    // Vector table
    for (int i = 0; i < 24; i++) begin
      iStall = vecs[i].stall;
      iBranchTaken = vecs[i].br;
      iBranchTarget = vecs[i].tgt;
      step();
      check($sformatf("v%0d_valid", i), 32'(oValid), 32'(vecs[i].exp_valid));
      check($sformatf("v%0d_addr", i), 32'(oAddress), 32'(vecs[i].exp_addr));
      if (vecs[i].exp_valid) begin
        check($sformatf("v%0d_opc", i), 32'(oPC), 32'(vecs[i].exp_pc));
        check($sformatf("v%0d_instr", i), 32'(oInstruction), 32'(rom[vecs[i].exp_pc]));
      end
    end
    iStall = 1'b0;
    iBranchTaken = 1'b0;

    // NOP with count 4000: bubble of 4001 cycles
    rom[0] = {OP_NOP, 24'd4000};
    do_reset();
    iBranchTaken = 1'b1;
    iBranchTarget = 16'h0000;
    step();
    iBranchTaken = 1'b0;
    check("nop_start_addr", 32'(oAddress), 32'd0);
    n = 0;
    for (int k = 0; k < 5000; k++) begin
      step();
      if (oValid) break;
      n++;
    end
    check("nop4000_bubble", 32'(n), 32'd4001);
    check("nop4000_next_opc", 32'(oPC), 32'd1);
    check("nop4000_next_valid", 32'(oValid), 32'd1);

    // Reset in the middle of a delay
    iBranchTaken = 1'b1;
    iBranchTarget = 16'h0000;
    step();
    iBranchTaken = 1'b0;
    for (int k = 0; k < 6; k++) step();
    check("mid_delay_valid", 32'(oValid), 32'd0);
    check("mid_delay_addr", 32'(oAddress), 32'd1);
    Reset = 1'b1;
    iStall = 1'b1;
    step();
    check("mid_rst_valid", 32'(oValid), 32'd0);
    check("mid_rst_opc", 32'(oPC), 32'd0);
    check("mid_rst_instr", 32'(oInstruction), 32'd0);
    check("mid_rst_addr", 32'(oAddress), 32'd1);
    Reset = 1'b0;
    iStall = 1'b0;
    step();
    check("post_rst_valid", 32'(oValid), 32'd1);
    check("post_rst_opc", 32'(oPC), 32'd1);
    check("post_rst_instr", 32'(oInstruction), 32'(rom[1]));

    // JMP to an ordinary instruction
    rom[0] = {OP_ADD, 24'h000AAA};
    iBranchTaken = 1'b1;
    iBranchTarget = 16'h0007;
    step();
    iBranchTaken = 1'b0;
    step();
    check("jmp_valid", 32'(oValid), 32'd0);
    check("jmp_instr", 32'(oInstruction), 32'(nop_word()));
    check("jmp_addr", 32'(oAddress), 32'd0);
    step();
    check("jmp_next_valid", 32'(oValid), 32'd1);
    check("jmp_next_opc", 32'(oPC), 32'd0);
    check("jmp_next_instr", 32'(oInstruction), 32'(rom[0]));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
